// File: rtl/legv8_instr_encoder.sv
// LEGv8 program loader: accepts one fielded instruction per handshake, packs it into a
// 32-bit R/I/D/B/CB word and writes it to sequential instruction-memory addresses.
module legv8_instr_encoder #(
    parameter int ADDR_W    = 6,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        op_sel,
    input  logic [4:0]        rd,
    input  logic [4:0]        rn,
    input  logic [4:0]        rm,
    input  logic [5:0]        shamt,
    input  logic [25:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [1:0] {S_IDLE, S_ENC, S_WR, S_FULL} state_t;

    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] CODE_OK    = 2'b00;
    localparam logic [1:0] CODE_ILLOP = 2'b01;
    localparam logic [1:0] CODE_RANGE = 2'b10;

    // Returns {error_code, word}; word is zero when the opcode is illegal.
    function automatic logic [33:0] encode_instr(
        input logic [4:0]  op,
        input logic [4:0]  f_rd,
        input logic [4:0]  f_rn,
        input logic [4:0]  f_rm,
        input logic [5:0]  f_shamt,
        input logic [25:0] f_imm
    );
        logic [31:0] w;
        logic [1:0]  c;
        logic        i_bad;
        logic        d_bad;
        logic        cb_bad;
        w      = 32'h0000_0000;
        c      = CODE_OK;
        i_bad  = (f_imm[25:12] != 14'd0);
        d_bad  = !((f_imm[25:8] == 18'h00000) || (f_imm[25:8] == 18'h3FFFF));
        cb_bad = !((f_imm[25:18] == 8'h00) || (f_imm[25:18] == 8'hFF));
        case (op)
            5'd0:  w = {11'b10001011000, f_rm, 6'd0, f_rn, f_rd};
            5'd1:  w = {11'b10001010000, f_rm, 6'd0, f_rn, f_rd};
            5'd2:  w = {11'b11001010000, f_rm, 6'd0, f_rn, f_rd};
            5'd3:  w = {11'b11010011011, 5'd0, f_shamt, f_rn, f_rd};
            5'd4:  w = {11'b11010011010, 5'd0, f_shamt, f_rn, f_rd};
            5'd5:  w = {11'b10101010000, f_rm, 6'd0, f_rn, f_rd};
            5'd6:  w = {11'b11001011000, f_rm, 6'd0, f_rn, f_rd};
            5'd7:  begin w = {10'b1001000100, f_imm[11:0], f_rn, f_rd}; c = i_bad ? CODE_RANGE : CODE_OK; end
            5'd8:  begin w = {10'b1001001000, f_imm[11:0], f_rn, f_rd}; c = i_bad ? CODE_RANGE : CODE_OK; end
            5'd9:  begin w = {10'b1101001000, f_imm[11:0], f_rn, f_rd}; c = i_bad ? CODE_RANGE : CODE_OK; end
            5'd10: begin w = {10'b1011001000, f_imm[11:0], f_rn, f_rd}; c = i_bad ? CODE_RANGE : CODE_OK; end
            5'd11: begin w = {10'b1101000100, f_imm[11:0], f_rn, f_rd}; c = i_bad ? CODE_RANGE : CODE_OK; end
            5'd12: begin w = {11'b11111000010, f_imm[8:0], 2'b00, f_rn, f_rd}; c = d_bad ? CODE_RANGE : CODE_OK; end
            5'd13: begin w = {11'b11111000000, f_imm[8:0], 2'b00, f_rn, f_rd}; c = d_bad ? CODE_RANGE : CODE_OK; end
            5'd14: w = {6'b000101, f_imm};
            5'd15: begin w = {8'b10110100, f_imm[18:0], f_rd}; c = cb_bad ? CODE_RANGE : CODE_OK; end
            5'd16: begin w = {8'b10110101, f_imm[18:0], f_rd}; c = cb_bad ? CODE_RANGE : CODE_OK; end
            default: c = CODE_ILLOP;
        endcase
        return {c, w};
    endfunction

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [4:0]        op_q, op_d, rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
    logic [5:0]        shamt_q, shamt_d;
    logic [25:0]       imm_q, imm_d;
    logic [33:0]       enc_s;

    // Next-state and next-output computation for the loader FSM.
    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        count_d     = count_q;
        full_d      = full_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        op_d        = op_q;
        rd_d        = rd_q;
        rn_d        = rn_q;
        rm_d        = rm_q;
        shamt_d     = shamt_q;
        imm_d       = imm_q;
        enc_s       = encode_instr(op_q, rd_q, rn_q, rm_q, shamt_q, imm_q);
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d    = op_sel;
                    rd_d    = rd;
                    rn_d    = rn;
                    rm_d    = rm;
                    shamt_d = shamt;
                    imm_d   = imm;
                    state_d = S_ENC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ENC: begin
                if (enc_s[33:32] != CODE_OK) begin
                    // Only the first error is kept; later ones are dropped silently.
                    if (!err_q) begin
                        err_d      = 1'b1;
                        err_code_d = enc_s[33:32];
                    end else begin
                        err_d      = err_q;
                    end
                    state_d = S_IDLE;
                end else begin
                    mem_wdata_d = enc_s[31:0];
                    mem_we_d    = 1'b1;
                    state_d     = S_WR;
                end
            end
            S_WR: begin
                mem_addr_d = mem_addr_q + ADDR_W'(1);
                count_d    = count_q + (ADDR_W + 1)'(1);
                if (count_d == DEPTH_C) begin
                    full_d  = 1'b1;
                    state_d = S_FULL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FULL: state_d = S_FULL;
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_IDLE);
    end

    // State and output registers; clear restarts exactly like rst.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_C;
            mem_wdata_q <= 32'h0000_0000;
            count_q     <= '0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
            op_q        <= 5'd0;
            rd_q        <= 5'd0;
            rn_q        <= 5'd0;
            rm_q        <= 5'd0;
            shamt_q     <= 6'd0;
            imm_q       <= 26'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            count_q     <= count_d;
            full_q      <= full_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            rn_q        <= rn_d;
            rm_q        <= rm_d;
            shamt_q     <= shamt_d;
            imm_q       <= imm_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign full      = full_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Self-checking bench for legv8_instr_encoder: directed spec vectors, boundaries,
// full/clear/reset scenarios and randomized instructions against an arithmetic model.
module tb_legv8_instr_encoder;

    localparam int ADDR_W    = 6;
    localparam int DEPTH     = 4;
    localparam int BASE_ADDR = 2;

    logic              clk = 1'b0;
    logic              rst, clear, in_valid, in_ready;
    logic [4:0]        op_sel, rd, rn, rm;
    logic [5:0]        shamt;
    logic [25:0]       imm;
    logic              mem_we, full, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic [1:0]        err_code;

    int          checks = 0;
    int          errors = 0;
    int          m_count;
    logic        m_err;
    logic [1:0]  m_code;
    logic [31:0] last_wdata;

    legv8_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rd(rd), .rn(rn), .rm(rm), .shamt(shamt), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count),
        .full(full), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Reference encoder built from field weights and signed value ranges.
    function automatic void model_encode(input int op, input int f_rd, input int f_rn,
                                         input int f_rm, input int f_sh, input logic [25:0] f_imm,
                                         output logic [31:0] w, output logic [1:0] code);
        longint r_opc [7] = '{1112, 1104, 1616, 1691, 1690, 1360, 1624};
        longint i_opc [5] = '{580, 584, 840, 712, 836};
        longint v;
        longint u;
        longint lw;
        v    = longint'($signed(f_imm));
        u    = longint'(f_imm);
        lw   = 0;
        code = 2'b00;
        if (op <= 6) begin
            if (op == 3 || op == 4) lw = r_opc[op] * 2097152 + f_sh * 1024 + f_rn * 32 + f_rd;
            else                    lw = r_opc[op] * 2097152 + f_rm * 65536 + f_rn * 32 + f_rd;
        end else if (op <= 11) begin
            if (u >= 4096) code = 2'b10;
            lw = i_opc[op - 7] * 4194304 + (u % 4096) * 1024 + f_rn * 32 + f_rd;
        end else if (op <= 13) begin
            if (v < -256 || v > 255) code = 2'b10;
            lw = (op == 12 ? 1986 : 1984) * 2097152 + ((v + 1048576) % 512) * 4096 + f_rn * 32 + f_rd;
        end else if (op == 14) begin
            lw = 5 * 67108864 + u;
        end else if (op <= 16) begin
            if (v < -262144 || v >= 262144) code = 2'b10;
            lw = (op == 15 ? 180 : 181) * 16777216 + ((v + 67108864) % 524288) * 32 + f_rd;
        end else begin
            code = 2'b01;
        end
        if (code == 2'b01) lw = 0;
        w = lw[31:0];
    endfunction

    task automatic reset_model();
        m_count = 0;
        m_err   = 1'b0;
        m_code  = 2'b00;
    endtask

    task automatic pulse_clear(input bit use_rst);
        @(negedge clk);
        in_valid = 1'b0;
        if (use_rst) rst = 1'b1;
        else         clear = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        clear = 1'b0;
        reset_model();
    endtask

    // Offers one instruction (caller sits at a negedge) and follows it through the pipeline.
    task automatic send_instr(input int op, input int f_rd, input int f_rn, input int f_rm,
                              input int f_sh, input logic [25:0] f_imm);
        logic [31:0] w;
        logic [1:0]  code;
        int          waited;
        model_encode(op, f_rd, f_rn, f_rm, f_sh, f_imm, w, code);
        op_sel = 5'(op); rd = 5'(f_rd); rn = 5'(f_rn); rm = 5'(f_rm); shamt = 6'(f_sh); imm = f_imm;
        if (m_count == DEPTH) begin
            in_valid = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                checks++;
                if (mem_we !== 1'b0 || in_ready !== 1'b0 || full !== 1'b1 || count !== (ADDR_W+1)'(m_count)) begin
                    errors++;
                    $display("FAIL full_hold: we=%b rdy=%b full=%b count=%0d, expected we=0 rdy=0 full=1 count=%0d",
                             mem_we, in_ready, full, count, m_count);
                end
            end
            in_valid = 1'b0;
            return;
        end
        waited = 0;
        while (in_ready !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: in_ready=%b, expected 1 within 8 cycles", in_ready);
            return;
        end
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (mem_we !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL enc_cycle: we=%b rdy=%b, expected we=0 rdy=0", mem_we, in_ready);
        end
        @(negedge clk);
        if (code == 2'b00) begin
            last_wdata = mem_wdata;
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(BASE_ADDR + m_count) || mem_wdata !== w) begin
                errors++;
                $display("FAIL write op=%0d: we=%b addr=%0d data=%h, expected we=1 addr=%0d data=%h",
                         op, mem_we, mem_addr, mem_wdata, BASE_ADDR + m_count, w);
            end
            m_count++;
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b0 || count !== (ADDR_W+1)'(m_count) || full !== (m_count == DEPTH) ||
                in_ready !== (m_count != DEPTH) || mem_addr !== ADDR_W'(BASE_ADDR + m_count) ||
                err !== m_err || err_code !== m_code) begin
                errors++;
                $display("FAIL post_write: we=%b count=%0d full=%b rdy=%b addr=%0d err=%b code=%b, expected we=0 count=%0d full=%b rdy=%b addr=%0d err=%b code=%b",
                         mem_we, count, full, in_ready, mem_addr, err, err_code,
                         m_count, m_count == DEPTH, m_count != DEPTH, BASE_ADDR + m_count, m_err, m_code);
            end
        end else begin
            if (!m_err) begin
                m_err  = 1'b1;
                m_code = code;
            end
            checks++;
            if (mem_we !== 1'b0 || err !== 1'b1 || err_code !== m_code || in_ready !== 1'b1 ||
                count !== (ADDR_W+1)'(m_count)) begin
                errors++;
                $display("FAIL error op=%0d: we=%b err=%b code=%b rdy=%b count=%0d, expected we=0 err=1 code=%b rdy=1 count=%0d",
                         op, mem_we, err, err_code, in_ready, count, m_code, m_count);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; in_valid = 1'b1;
        op_sel = 5'd0; rd = 5'd1; rn = 5'd2; rm = 5'd3; shamt = 6'd0; imm = 26'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        reset_model();
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== ADDR_W'(BASE_ADDR) || mem_wdata !== 32'h0 || count !== '0 ||
            full !== 1'b0 || err !== 1'b0 || err_code !== 2'b00 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: we=%b addr=%0d data=%h count=%0d full=%b err=%b code=%b rdy=%b, expected 0 %0d 0 0 0 0 00 1",
                     mem_we, mem_addr, mem_wdata, count, full, err, err_code, in_ready, BASE_ADDR);
        end
    endtask

    task automatic test_spec_vectors();
        logic [31:0] exp_w [5] = '{32'h8B020023, 32'h91001401, 32'hF8408022, 32'h17FFFFFD, 32'hB4000045};
        pulse_clear(1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) pulse_clear(1'b0);
            case (i)
                0: send_instr(0, 3, 1, 2, 0, 26'd0);
                1: send_instr(7, 1, 0, 0, 0, 26'd5);
                2: send_instr(12, 2, 1, 0, 0, 26'd8);
                3: send_instr(14, 0, 0, 0, 0, 26'h3FFFFFD);
                default: send_instr(15, 5, 0, 0, 0, 26'd2);
            endcase
            checks++;
            if (last_wdata !== exp_w[i]) begin
                errors++;
                $display("FAIL spec_vector%0d: got %h, expected %h", i, last_wdata, exp_w[i]);
            end
        end
    endtask

    task automatic test_errors();
        pulse_clear(1'b0);
        send_instr(7, 1, 0, 0, 0, 26'd4096);
        send_instr(20, 1, 0, 0, 0, 26'd0);
        send_instr(7, 1, 0, 0, 0, 26'd4095);
        pulse_clear(1'b1);
        send_instr(17, 0, 0, 0, 0, 26'd0);
        pulse_clear(1'b0);
        send_instr(12, 4, 6, 0, 0, 26'd255);
        send_instr(13, 4, 6, 0, 0, 26'h3FFFF00);
        send_instr(12, 4, 6, 0, 0, 26'd256);
        send_instr(13, 4, 6, 0, 0, 26'h3FFFEFF);
        pulse_clear(1'b0);
        send_instr(15, 7, 0, 0, 0, 26'd262143);
        send_instr(16, 7, 0, 0, 0, 26'h3FC0000);
        send_instr(15, 7, 0, 0, 0, 26'd262144);
        send_instr(14, 0, 0, 0, 0, 26'h2000000);
    endtask

    task automatic test_back_to_back();
        int nwr;
        pulse_clear(1'b0);
        op_sel = 5'd0; rd = 5'd3; rn = 5'd1; rm = 5'd2; shamt = 6'd9; imm = 26'd0;
        in_valid = 1'b1;
        nwr = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== (k % 3 == 2)) begin
                errors++;
                $display("FAIL b2b_we cycle%0d: we=%b, expected %b", k, mem_we, k % 3 == 2);
            end
            if (k % 3 == 2) begin
                checks++;
                if (mem_addr !== ADDR_W'(BASE_ADDR + nwr) || mem_wdata !== 32'h8B020023) begin
                    errors++;
                    $display("FAIL b2b_write%0d: addr=%0d data=%h, expected addr=%0d data=8b020023",
                             nwr, mem_addr, mem_wdata, BASE_ADDR + nwr);
                end
                nwr++;
            end
        end
        in_valid = 1'b0;
        m_count  = DEPTH;
        checks++;
        if (full !== 1'b1 || in_ready !== 1'b0 || count !== (ADDR_W+1)'(DEPTH)) begin
            errors++;
            $display("FAIL b2b_full: full=%b rdy=%b count=%0d, expected 1 0 %0d", full, in_ready, count, DEPTH);
        end
        send_instr(5, 1, 1, 1, 0, 26'd0);
        pulse_clear(1'b0);
        checks++;
        if (count !== '0 || mem_addr !== ADDR_W'(BASE_ADDR) || full !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_after_full: count=%0d addr=%0d full=%b rdy=%b, expected 0 %0d 0 1",
                     count, mem_addr, full, in_ready, BASE_ADDR);
        end
    endtask

    task automatic test_clear_rst_midflight();
        pulse_clear(1'b0);
        send_instr(1, 2, 3, 4, 0, 26'd0);
        op_sel = 5'd6; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL clear_wr_strobe: we=%b, expected 1", mem_we);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        reset_model();
        checks++;
        if (mem_we !== 1'b0 || count !== '0 || mem_addr !== ADDR_W'(BASE_ADDR) || in_ready !== 1'b1 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL clear_during_write: we=%b count=%0d addr=%0d rdy=%b data=%h, expected 0 0 %0d 1 0",
                     mem_we, count, mem_addr, in_ready, mem_wdata, BASE_ADDR);
        end
        send_instr(2, 2, 3, 4, 0, 26'd0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        checks++;
        if (mem_we !== 1'b0 || count !== '0 || mem_addr !== ADDR_W'(BASE_ADDR) || mem_wdata !== 32'h0 ||
            in_ready !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_enc: we=%b count=%0d addr=%0d data=%h rdy=%b err=%b, expected 0 0 %0d 0 1 0",
                     mem_we, count, mem_addr, mem_wdata, in_ready, err, BASE_ADDR);
        end
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_enc_nowrite: we=%b, expected 0", mem_we);
        end
    endtask

    task automatic test_random();
        int op;
        logic [25:0] r_imm;
        pulse_clear(1'b0);
        for (int n = 0; n < 80; n++) begin
            if ((m_count == DEPTH && $urandom_range(0, 3) != 0) || (m_err && $urandom_range(0, 2) == 0))
                pulse_clear($urandom_range(0, 1) == 1);
            op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 16));
            case ($urandom_range(0, 3))
                0: r_imm = 26'($urandom);
                1: r_imm = 26'($urandom_range(0, 4200));
                2: r_imm = 26'(-int'($urandom_range(1, 300)));
                default: r_imm = 26'($urandom_range(262000, 262200));
            endcase
            send_instr(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                       int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), r_imm);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        last_wdata = 32'h0;
        test_reset();
        test_spec_vectors();
        test_errors();
        test_back_to_back();
        test_clear_rst_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
